// File: rtl/mult4_seq_sched_pkg.sv
// Shared types and helpers for the sequential partial-product multiplier scheduler.
// The state enum sequences the four half-width partial products; shift_for gives each one's weight.
package mult_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LL   = 3'd1,
        LH   = 3'd2,
        HL   = 3'd3,
        HH   = 3'd4,
        DONE = 3'd5
    } state_t;

    // Left shift applied to each partial product before accumulation.
    function automatic int unsigned shift_for(input state_t s, input int unsigned h);
        int unsigned sh;
        case (s)
            LH, HL:  sh = h;
            HH:      sh = 32'd2 * h;
            default: sh = 32'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mult4_seq_sched_mult2_exact.sv
// Exact unsigned H x H -> 2H partial-product cell.
// It keeps the same pins as the approximate cells so that either can be dropped in.
module mult2_exact #(
    parameter int H = 2
) (
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    output logic [2*H-1:0] p
);

    assign p = {{H{1'b0}}, a} * {{H{1'b0}}, b};

endmodule

// File: rtl/mult4_seq_sched.sv
// DW x DW unsigned multiplier built from one time-multiplexed (DW/2)x(DW/2) cell.
// Partial products LL, LH, HL, HH are accumulated over four cycles, with valid/ready on both sides.
module mult4_seq_sched
    import mult_seq_pkg::*;
#(
    parameter int DW = 4,
    localparam int H = DW / 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] p,
    output logic            busy
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DW-1:0]     a_r;
    logic [DW-1:0]     b_r;
    logic [2*DW-1:0]   acc_r;
    logic [H-1:0]      op_a_s;
    logic [H-1:0]      op_b_s;
    logic [2*H-1:0]    pp_s;
    logic [2*DW-1:0]   pp_ext_s;
    logic              accept_s;
    logic              busy_s;
    logic              in_ready_s;

    // Status decode and accept qualification from the current state.
    always_comb begin
        busy_s     = 1'b0;
        in_ready_s = 1'b0;
        if ((state_r == LL) || (state_r == LH) || (state_r == HL) || (state_r == HH)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
        if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == DONE) begin
            in_ready_s = out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s  = in_valid && in_ready_s;
    assign in_ready  = in_ready_s;
    assign busy      = busy_s;
    assign out_valid = (state_r == DONE);
    assign p         = acc_r;

    // Next-state logic; DONE can hand straight over to LL for gap-free throughput.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = LL;
                else          state_nxt_s = IDLE;
            end
            LL:   state_nxt_s = LH;
            LH:   state_nxt_s = HL;
            HL:   state_nxt_s = HH;
            HH:   state_nxt_s = DONE;
            DONE: begin
                if (accept_s)       state_nxt_s = LL;
                else if (out_ready) state_nxt_s = IDLE;
                else                state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Operand selection for the shared half-width cell.
    always_comb begin
        op_a_s = '0;
        op_b_s = '0;
        case (state_r)
            LL: begin op_a_s = a_r[H-1:0];  op_b_s = b_r[H-1:0];  end
            LH: begin op_a_s = a_r[H-1:0];  op_b_s = b_r[DW-1:H]; end
            HL: begin op_a_s = a_r[DW-1:H]; op_b_s = b_r[H-1:0];  end
            HH: begin op_a_s = a_r[DW-1:H]; op_b_s = b_r[DW-1:H]; end
            default: begin op_a_s = '0; op_b_s = '0; end
        endcase
    end

    mult2_exact #(.H(H)) u_pp (
        .a (op_a_s),
        .b (op_b_s),
        .p (pp_s)
    );

    assign pp_ext_s = {{(2*DW-2*H){1'b0}}, pp_s};

    // Operand capture and shifted accumulation; the sum is a*b so it never overflows 2*DW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            acc_r <= '0;
        end else if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            acc_r <= '0;
        end else if (busy_s) begin
            acc_r <= acc_r + (pp_ext_s << shift_for(state_r, H));
        end
    end

endmodule

// File: tb/tb_mult4_seq_sched.sv
// Directed self-checking bench for mult4_seq_sched at DW=4, plus a random DW=8 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mult4_seq_sched;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0] a, b;
    logic [7:0] p;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_assert = 0;
    int n_fail   = 0;

    mult4_seq_sched #(.DW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    mult4_seq_sched #(.DW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction with latency and busy-window checks; starts and ends on a negedge.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic [7:0] exp,
                          input string tag);
        a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_p"}, {24'd0, p}, {24'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] held;
        int          waited;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 4'd0; b = 4'd0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_p", {24'd0, p}, 32'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(4'd15, 4'd15, 8'd225, "single_15x15");
        chk("idle_after_single", {31'd0, out_valid}, 32'd0);
        run_op(4'd0, 4'd13, 8'd0, "zero");
        run_op(4'd1, 4'd9, 8'd9, "identity");
        run_op(4'd9, 4'd6, 8'd54, "9x6");

        // Back-to-back: (3,5) (12,7) (15,1) with in_valid and out_ready held high.
        a = 4'd3; b = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (i == 0 && k == 0) begin a = 4'd12; b = 4'd7; end
                if (i == 0 && k == 1) begin a = 4'd15; b = 4'd1; end
                chk("b2b_in_ready_low", {31'd0, in_ready}, 32'd0);
                chk("b2b_busy", {31'd0, busy}, 32'd1);
            end
            @(negedge clk);
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_in_ready_done", {31'd0, in_ready}, 32'd1);
            chk("b2b_p", {24'd0, p}, (k == 1) ? 32'd84 : 32'd15);
            if (k == 2) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", {31'd0, out_valid}, 32'd0);

        // Backpressure: 10x11 held while out_ready=0, other operands offered meanwhile.
        a = 4'd10; b = 4'd11; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a = 4'd2; b = 4'd2;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_p", {24'd0, p}, 32'd110);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        chk("bp_release_p", {24'd0, p}, 32'd110);
        @(negedge clk);
        chk("bp_once", {31'd0, out_valid}, 32'd0);

        // Reset while in HL: everything visible clears at once.
        a = 4'd5; b = 4'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_p", {24'd0, p}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'd6, 4'd7, 8'd42, "after_rst");

        // Exhaustive DW=4 sweep.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = i[7:0];
            a = iv[7:4]; b = iv[3:0]; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            waited = 0;
            while (!out_valid && waited < 10) begin @(negedge clk); waited++; end
            chk("sweep_p", {24'd0, p}, {24'd0, ({4'd0, iv[7:4]} * {4'd0, iv[3:0]})});
            @(negedge clk);
        end

        // DW=8 random pairs with random backpressure.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
            a8 = ra; b8 = rb; in_valid8 = 1'b1; out_ready8 = 1'b0;
            @(negedge clk);
            in_valid8 = 1'b0;
            waited = 0;
            while (!out_valid8 && waited < 12) begin @(negedge clk); waited++; end
            held = {8'd0, ra} * {8'd0, rb};
            chk("rand8_p", {16'd0, p8}, {16'd0, held});
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                @(negedge clk);
                chk("rand8_hold", {16'd0, p8}, {16'd0, held});
            end
            out_ready8 = 1'b1;
            @(negedge clk);
            chk("rand8_done", {31'd0, out_valid8}, 32'd0);
            out_ready8 = 1'($urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
